// File: rtl/mux4_scan_ctrl.sv
// mux4_scan_ctrl: round-robin select sequencer for a 4-to-1 mux.
// Holds each enabled channel for DWELL cycles, then captures f_in with a
// channel tag and a one-cycle valid strobe.
// Ports: clk, rst_n (async, active-low), start, stop, en_mask[3:0],
//        f_in[WIDTH-1:0] -> s0, s1, sample[WIDTH-1:0], sample_ch[1:0],
//        sample_valid, busy.
// Option: define MUX4_SCAN_ONESHOT_EN for a single pass over the mask.
module mux4_scan_ctrl #(
    parameter int WIDTH = 3,
    parameter int DWELL = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic [3:0]       en_mask,
    input  logic [WIDTH-1:0] f_in,
    output logic             s0,
    output logic             s1,
    output logic [WIDTH-1:0] sample,
    output logic [1:0]       sample_ch,
    output logic             sample_valid,
    output logic             busy
);

    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

    state_t           state_q;
    logic [1:0]       cur_ch_q;
    logic [CW-1:0]    cnt_q;
    logic             stop_pend_q;
    logic [WIDTH-1:0] sample_q;
    logic [1:0]       sample_ch_q;
    logic             sample_valid_q;
    logic             busy_q;

    logic [1:0]       lo_ch_d;
    logic [1:0]       nxt_ch_d;
    logic             exit_d;
    logic             found;
    logic [2:0]       sum;
`ifdef MUX4_SCAN_ONESHOT_EN
    logic             wrap;
`endif

    // Lowest enabled channel, used as the first channel of a scan.
    always_comb begin
        lo_ch_d = 2'd0;
        if (en_mask[0])      lo_ch_d = 2'd0;
        else if (en_mask[1]) lo_ch_d = 2'd1;
        else if (en_mask[2]) lo_ch_d = 2'd2;
        else if (en_mask[3]) lo_ch_d = 2'd3;
    end

    // Next enabled channel after cur_ch with wrap 3->0. Step 4 lands
    // back on cur_ch, covering the single-channel case. The carry bit of
    // the search marks a wrap, which ends a one-shot pass.
    always_comb begin
        nxt_ch_d = cur_ch_q;
        found    = 1'b0;
        sum      = 3'd0;
`ifdef MUX4_SCAN_ONESHOT_EN
        wrap     = 1'b0;
`endif
        for (int k = 1; k <= 4; k++) begin
            sum = {1'b0, cur_ch_q} + 3'(k);
            if (!found && en_mask[sum[1:0]]) begin
                found    = 1'b1;
                nxt_ch_d = sum[1:0];
`ifdef MUX4_SCAN_ONESHOT_EN
                wrap     = sum[2];
`endif
            end
        end
        exit_d = stop_pend_q | stop | (en_mask == 4'b0000);
`ifdef MUX4_SCAN_ONESHOT_EN
        exit_d = exit_d | wrap;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            cur_ch_q       <= 2'd0;
            cnt_q          <= '0;
            stop_pend_q    <= 1'b0;
            sample_q       <= '0;
            sample_ch_q    <= 2'd0;
            sample_valid_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            sample_valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start && (en_mask != 4'b0000)) begin
                        state_q     <= SCAN;
                        cur_ch_q    <= lo_ch_d;
                        cnt_q       <= '0;
                        stop_pend_q <= 1'b0;
                        busy_q      <= 1'b1;
                    end
                end
                SCAN: begin
                    if (stop) stop_pend_q <= 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        sample_q       <= f_in;
                        sample_ch_q    <= cur_ch_q;
                        sample_valid_q <= 1'b1;
                        cnt_q          <= '0;
                        if (exit_d) begin
                            state_q     <= IDLE;
                            busy_q      <= 1'b0;
                            stop_pend_q <= 1'b0;
                        end else begin
                            cur_ch_q <= nxt_ch_d;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign s0           = cur_ch_q[0];
    assign s1           = cur_ch_q[1];
    assign sample       = sample_q;
    assign sample_ch    = sample_ch_q;
    assign sample_valid = sample_valid_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_mux4_scan_ctrl.sv
// tb_mux4_scan_ctrl: directed bench for mux4_scan_ctrl (WIDTH=3, DWELL=4).
// The mux is modelled with w0..w3 = 1..4.
module tb_mux4_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [3:0] en_mask = 4'b0000;
    logic [2:0] f_in;
    logic       s0;
    logic       s1;
    logic [2:0] sample;
    logic [1:0] sample_ch;
    logic       sample_valid;
    logic       busy;
    logic [1:0] sel;

    int checks = 0;
    int failures = 0;

    mux4_scan_ctrl #(.WIDTH(3), .DWELL(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .stop(stop),
        .en_mask(en_mask),
        .f_in(f_in),
        .s0(s0),
        .s1(s1),
        .sample(sample),
        .sample_ch(sample_ch),
        .sample_valid(sample_valid),
        .busy(busy)
    );

    always #5 clk = ~clk;

    assign sel = {s1, s0};

    // Mux model: w0=1, w1=2, w2=3, w3=4.
    always_comb f_in = 3'({1'b0, sel}) + 3'd1;

    task automatic do_reset();
        rst_n   = 1'b0;
        start   = 1'b0;
        stop    = 1'b0;
        en_mask = 4'b0000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Leaves the bench at the negedge right after the start edge (c=0).
    task automatic start_scan(input logic [3:0] m);
        en_mask = m;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({sel, sample, sample_ch, sample_valid, busy} !== 9'd0) begin
            failures++;
            $display("FAIL reset: got sel=%0d sample=%0d ch=%0d v=%0b busy=%0b required all 0",
                     sel, sample, sample_ch, sample_valid, busy);
        end
        do_reset();
    endtask

    task automatic test_full_scan();
        logic [1:0] esel;
        logic       ev;
        do_reset();
        start_scan(4'b1111);
        for (int c = 0; c <= 20; c++) begin
            esel = 2'((c / 4) % 4);
            ev   = (c >= 4) && (c % 4 == 0);
            checks++;
            if (sel !== esel || busy !== 1'b1) begin
                failures++;
                $display("FAIL full_sel c=%0d: got sel=%0d busy=%0b required sel=%0d busy=1",
                         c, sel, busy, esel);
            end
            checks++;
            if (sample_valid !== ev) begin
                failures++;
                $display("FAIL full_valid c=%0d: got %0b required %0b", c, sample_valid, ev);
            end
            if (ev) begin
                checks++;
                if (sample_ch !== 2'((c / 4 - 1) % 4) ||
                    sample !== 3'((c / 4 - 1) % 4 + 1)) begin
                    failures++;
                    $display("FAIL full_sample c=%0d: got ch=%0d val=%0d required ch=%0d val=%0d",
                             c, sample_ch, sample, (c / 4 - 1) % 4, (c / 4 - 1) % 4 + 1);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_sparse_mask();
        logic [1:0] esel;
        logic [1:0] ech;
        logic       ev;
        do_reset();
        start_scan(4'b1010);
        for (int c = 0; c <= 16; c++) begin
            esel = ((c / 4) % 2 == 1) ? 2'd3 : 2'd1;
            ech  = ((c / 4 - 1) % 2 == 1) ? 2'd3 : 2'd1;
            ev   = (c >= 4) && (c % 4 == 0);
            checks++;
            if (sel !== esel) begin
                failures++;
                $display("FAIL sparse_sel c=%0d: got %0d required %0d", c, sel, esel);
            end
            checks++;
            if (sample_valid !== ev) begin
                failures++;
                $display("FAIL sparse_valid c=%0d: got %0b required %0b", c, sample_valid, ev);
            end
            if (ev) begin
                checks++;
                if (sample_ch !== ech || sample !== 3'(ech) + 3'd1) begin
                    failures++;
                    $display("FAIL sparse_sample c=%0d: got ch=%0d val=%0d required ch=%0d val=%0d",
                             c, sample_ch, sample, ech, ech + 1);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_empty_mask();
        do_reset();
        start_scan(4'b0000);
        for (int c = 0; c < 6; c++) begin
            checks++;
            if (busy !== 1'b0 || sample_valid !== 1'b0 || sel !== 2'd0) begin
                failures++;
                $display("FAIL empty c=%0d: got busy=%0b v=%0b sel=%0d required 0 0 0",
                         c, busy, sample_valid, sel);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_stop();
        do_reset();
        start_scan(4'b1111);
        repeat (9) @(negedge clk);
        // c=9: channel 2 selected with cnt=1
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        repeat (2) @(negedge clk);
        // c=12: final capture visible
        checks++;
        if (sample_valid !== 1'b1 || sample !== 3'd3 || sample_ch !== 2'd2 || busy !== 1'b0) begin
            failures++;
            $display("FAIL stop_last: got v=%0b val=%0d ch=%0d busy=%0b required 1 3 2 0",
                     sample_valid, sample, sample_ch, busy);
        end
        for (int c = 13; c <= 20; c++) begin
            @(negedge clk);
            checks++;
            if (sample_valid !== 1'b0 || busy !== 1'b0 || sel !== 2'd2) begin
                failures++;
                $display("FAIL stop_idle c=%0d: got v=%0b busy=%0b sel=%0d required 0 0 2",
                         c, sample_valid, busy, sel);
            end
        end
    endtask

    task automatic test_reset_mid_scan();
        do_reset();
        start_scan(4'b1111);
        repeat (6) @(negedge clk);
        // c=6: channel 1 dwelling, sample still holds ch0 value 1
        checks++;
        if (sel !== 2'd1 || sample !== 3'd1) begin
            failures++;
            $display("FAIL rstmid_pre: got sel=%0d val=%0d required 1 1", sel, sample);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({sel, sample, sample_ch, sample_valid, busy} !== 9'd0) begin
            failures++;
            $display("FAIL rstmid_async: got sel=%0d val=%0d ch=%0d v=%0b busy=%0b required all 0",
                     sel, sample, sample_ch, sample_valid, busy);
        end
        @(negedge clk);
        rst_n   = 1'b1;
        en_mask = 4'b1110;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || sample_valid !== 1'b0) begin
                failures++;
                $display("FAIL rstmid_idle c=%0d: got busy=%0b v=%0b required 0 0",
                         c, busy, sample_valid);
            end
        end
        start_scan(4'b1110);
        checks++;
        if (busy !== 1'b1 || sel !== 2'd1) begin
            failures++;
            $display("FAIL rstmid_restart: got busy=%0b sel=%0d required 1 1", busy, sel);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (sample_valid !== 1'b1 || sample_ch !== 2'd1 || sample !== 3'd2) begin
            failures++;
            $display("FAIL rstmid_sample: got v=%0b ch=%0d val=%0d required 1 1 2",
                     sample_valid, sample_ch, sample);
        end
    endtask

    task automatic test_oneshot();
        logic ev;
        do_reset();
        start_scan(4'b0111);
        for (int c = 0; c <= 20; c++) begin
            ev = (c == 4) || (c == 8) || (c == 12);
            checks++;
            if (sample_valid !== ev) begin
                failures++;
                $display("FAIL oneshot_valid c=%0d: got %0b required %0b", c, sample_valid, ev);
            end
            if (ev) begin
                checks++;
                if (sample_ch !== 2'(c / 4 - 1) || sample !== 3'(c / 4)) begin
                    failures++;
                    $display("FAIL oneshot_sample c=%0d: got ch=%0d val=%0d required ch=%0d val=%0d",
                             c, sample_ch, sample, c / 4 - 1, c / 4);
                end
            end
            checks++;
            if (busy !== (c < 12)) begin
                failures++;
                $display("FAIL oneshot_busy c=%0d: got %0b required %0b", c, busy, c < 12);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
`ifdef MUX4_SCAN_ONESHOT_EN
        test_oneshot();
`else
        test_full_scan();
        test_sparse_mask();
`endif
        test_empty_mask();
        test_stop();
        test_reset_mid_scan();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux4_scan_ctrl.md
# mux4_scan_ctrl

Sequencer that sits directly upstream of the 4-to-1 select mux (`mux4to1_design`, ports `s0`/`s1`/`w0..w3`/`f`). It drives the mux select lines round-robin over a set of enabled channels. It holds each select for a programmable dwell time, then registers the mux output `f` with a channel tag and a one-cycle valid strobe. Downstream logic consumes the tagged samples.

## Interface
- `WIDTH`, default 3: data width of mux output `f` and of `sample`.
- `DWELL`, default 4: cycles each channel stays selected; legal range 1..255.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `start`  in  1: level; in IDLE with a nonzero mask, begins a scan.
- `stop`  in  1: level; requests a stop at the next channel boundary.
- `en_mask`  in  4: bit i = channel i enabled.
- `f_in`  in  WIDTH: mux output `f`.
- `s0`  out  1: select LSB, connects to mux `s0`.
- `s1`  out  1: select MSB, connects to mux `s1`.
- `sample`  out  WIDTH: last captured `f_in`.
- `sample_ch`  out  2: channel index of `sample`.
- `sample_valid`  out  1: one-cycle strobe, new sample.
- `busy`  out  1: high while in SCAN.

## Operation
- States: IDLE, SCAN. Internal registers:
  - `cur_ch[1:0]`, which drives `{s1,s0}`.
  - Dwell counter `cnt`, width ceil(log2(DWELL)), minimum 1 bit.
  - `stop_pend`.
- **IDLE**
  - If `start=1` and `en_mask!=0`: load `cur_ch` with the lowest set bit of `en_mask`, clear `cnt` and `stop_pend`, go to SCAN.
  - If `start=1` and `en_mask==0`: stay in IDLE, no outputs change.
- **SCAN**
  - `cnt` increments every cycle.
  - Any cycle with `stop=1` sets `stop_pend`.
- **Capture edge** (`cnt==DWELL-1`), all on the same edge:
  - `sample<=f_in`, `sample_ch<=cur_ch`, `sample_valid<=1`, `cnt<=0`.
  - Next channel: the first set bit of `en_mask` strictly after `cur_ch`, searching upward with wrap 3->0. `en_mask` is sampled on this edge.
  - If `cur_ch` is the only enabled channel, it is reselected.
- **Leaving SCAN at the capture edge**
  - Exit condition: `stop_pend`, or `stop` asserted in the same cycle, or `en_mask==0`.
  - On exit: go to IDLE, hold `cur_ch` unchanged, `busy<=0`. The final sample is still delivered.
- `start` while in SCAN is ignored.
- `en_mask` changes mid-dwell have no effect until the capture edge.
- `sample`/`sample_ch` hold their values until the next capture.
- `sample_valid` is high for exactly one cycle per capture.

## Timing
- **Reset values** (asynchronous, take effect immediately on `rst_n=0`): `s0=0`, `s1=0`, `sample=0`, `sample_ch=0`, `sample_valid=0`, `busy=0`, state IDLE, `cnt=0`, `stop_pend=0`.
- **Reset mid-scan**: aborts without a final sample. The FSM stays in IDLE after release until `start` is seen.
- **Start**:
  - `start` is sampled at edge E0.
  - `busy` and the first select are valid after E0.
- **Per channel**: exactly DWELL cycles of stable select.
  - Capture at edge E0+DWELL, where `f_in` is combinational from `{s1,s0}`.
  - `sample_valid` is high during the cycle after the capture edge.
- **Throughput**: one sample every DWELL cycles, with no gap between channels.
- **DWELL=1**: select advances every cycle, and `sample_valid` is continuously high while scanning.
- **Stop**: the last sample's strobe coincides with the first cycle of `busy=0`.

## Configuration
- `MUX4_SCAN_ONESHOT_EN` defined: one-pass mode.
  - SCAN ends after capturing the highest enabled channel: a capture where the next-channel search wraps, or where the current channel is the only enabled one.
  - The FSM then enters IDLE exactly as on stop.
- Not defined: continuous round-robin until stop or an empty mask.

## Test plan
- **Full scan**
  - Setup: WIDTH=3, DWELL=4, mask 1111; bench models the mux with w0=1, w1=2, w2=3, w3=4; pulse `start`.
  - Required: samples 1,2,3,4,1 with `sample_ch` 0,1,2,3,0, strobes 4 cycles apart.
  - Required: `{s1,s0}` stable for 4 cycles each.
- **Sparse mask**
  - Setup: mask 1010.
  - Required: channels 1,3,1,3 with samples 2,4,2,4. Select never shows 0 or 2.
- **Empty mask**
  - Setup: `start` with mask 0000.
  - Required: `busy` stays 0, no strobe, `{s1,s0}=00`.
- **Stop mid-dwell**
  - Setup: pulse `stop` for 1 cycle at `cnt=1` on channel 2.
  - Required: channel 2 sample (3) is still delivered. Then `busy=0`, select holds 2'b10, and no further strobes.
- **Reset mid-scan**
  - Setup: drop `rst_n` during channel 1's dwell.
  - Required: all outputs 0 immediately and no strobe for channel 1. After release, `start` resumes from the lowest enabled channel.
- **One-shot** (`MUX4_SCAN_ONESHOT_EN`)
  - Setup: mask 0111.
  - Required: exactly 3 strobes (ch 0,1,2, values 1,2,3), then IDLE with `busy=0`.
